// File: rtl/quadra_pkg.sv
// Shared quadra constants: evaluator latency and result width.
package quadra_pkg;
   localparam int QUADRA_LATENCY = 3;
   localparam int QUADRA_DW      = 25;

   typedef logic signed [QUADRA_DW-1:0] y_t;
endpackage

// File: rtl/quadra_ofifo.sv
// Show-ahead FIFO for evaluator results; the head is visible as soon as count is non-zero.
module quadra_ofifo
   import quadra_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DW    = QUADRA_DW
) (
   input  logic                       clk,
   input  logic                       rst_b,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DW-1:0]              din,
   output logic [DW-1:0]              dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;

   assign do_pop = pop & ~empty;
   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign dout   = mem[rd_ptr];

   // Caller only pushes into a full FIFO together with a pop, so the slot being
   // overwritten is the head that leaves on this same edge.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/quadra_ostream.sv
// Output streamer behind the quadra evaluator: aligns a valid flag to the evaluator latency,
// buffers results in a FIFO and hands out input credit so buffered + in-flight never exceeds DEPTH.
module quadra_ostream
   import quadra_pkg::*;
#(
   parameter int LATENCY = QUADRA_LATENCY,
   parameter int DEPTH   = 8,
   parameter int DW      = QUADRA_DW
) (
   input  logic                       clk,
   input  logic                       rst_b,
   input  logic                       in_vld,
   output logic                       in_rdy,
   input  logic [DW-1:0]              y,
   output logic                       out_vld,
   input  logic                       out_rdy,
   output logic [DW-1:0]              out_data,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       ovf,
   input  logic                       clr_ovf
);
   localparam int CW = $clog2(DEPTH+1);

   logic [LATENCY-1:0] vld_pipe;
   logic               push;
   logic               pop;
   logic               wr_en;
   logic               ovf_set;
   logic               full;
   logic               empty;
   logic [CW-1:0]      count;
   logic [CW:0]        inflight;
   logic [CW:0]        credit_used;

   // The evaluator cannot stall, so a sample offered without credit still travels
   // down the delay line; if it lands on a full FIFO it is dropped and flagged in ovf.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) vld_pipe <= '0;
      else        vld_pipe <= (vld_pipe << 1) | LATENCY'(in_vld);
   end

   assign push    = vld_pipe[LATENCY-1];
   assign pop     = out_vld & out_rdy;
   assign wr_en   = push & (~full | pop);
   assign ovf_set = push & full & ~pop;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) begin
         inflight = inflight + {{CW{1'b0}}, vld_pipe[i]};
      end
   end

   assign credit_used = {1'b0, count} + inflight;
   assign in_rdy      = (credit_used < (CW+1)'(DEPTH));

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b)       ovf <= 1'b0;
      else if (ovf_set) ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
   end

   quadra_ofifo #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_ofifo (
      .clk   (clk),
      .rst_b (rst_b),
      .push  (wr_en),
      .pop   (pop),
      .din   (y),
      .dout  (out_data),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign out_vld = ~empty;
   assign level   = count;
endmodule

// File: tb/tb_quadra_ostream.sv
// Scoreboard bench for quadra_ostream with a 3-cycle evaluator stand-in driving y.
module tb_quadra_ostream;
   localparam int DW = 25;

   logic          clk = 1'b0;
   logic          rst_b;
   logic          in_vld;
   logic          in_rdy;
   logic [DW-1:0] y;
   logic          out_vld;
   logic          out_rdy;
   logic [DW-1:0] out_data;
   logic [3:0]    level;
   logic          ovf;
   logic          clr_ovf;

   logic [DW-1:0] x_val;
   logic [DW-1:0] xs1;
   logic [DW-1:0] xs2;
   logic [DW-1:0] y_r;

   logic [DW-1:0] exp_q[$];
   int            n_pass = 0;
   int            n_total = 0;

   always #5 clk = ~clk;

   quadra_ostream dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .y        (y),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_data (out_data),
      .level    (level),
      .ovf      (ovf),
      .clr_ovf  (clr_ovf)
   );

   // Evaluator stand-in: the value offered with a sample appears on y three edges later.
   always @(posedge clk) begin
      xs1 <= x_val;
      xs2 <= xs1;
      y_r <= xs2;
   end
   assign y = y_r;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [DW-1:0] rnd();
      return DW'($urandom);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic keep, input logic [DW-1:0] val);
      in_vld = vld;
      x_val  = val;
      if (vld && keep) exp_q.push_back(val);
   endtask

   // Offer samples only while credit is granted; stops at the first in_rdy=0.
   task automatic fill(output int grants, input int neg_at);
      grants = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!in_rdy) begin
            drive(1'b0, 1'b0, rnd());
            break;
         end
         drive(1'b1, 1'b1, (grants == neg_at) ? 25'h1FFFFF0 : rnd());
         grants++;
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         drive(1'b0, 1'b0, rnd());
      end
   endtask

   task automatic drain(input string name);
      out_rdy = 1'b1;
      drive(1'b0, 1'b0, rnd());
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
      chk({name, "_level0"}, 32'(level), 32'd0);
      chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
      out_rdy = 1'b0;
   endtask

   // Monitor: whenever a result is presented it must be the oldest expected value.
   always @(negedge clk) begin
      if (rst_b && out_vld) begin
         chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(exp_q[0]));
            if (out_rdy) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int grants;
      int issued;
      rst_b   = 1'b1;
      in_vld  = 1'b0;
      out_rdy = 1'b0;
      clr_ovf = 1'b0;
      x_val   = '0;
      #2 rst_b = 1'b0;
      #10;
      chk("rst_out_vld", 32'(out_vld), 32'd0);
      chk("rst_level",   32'(level),   32'd0);
      chk("rst_ovf",     32'(ovf),     32'd0);
      chk("rst_in_rdy",  32'(in_rdy),  32'd1);
      tick();
      rst_b = 1'b1;

      // Single sample: visible LATENCY+1 cycles after in_vld.
      tick();
      drive(1'b1, 1'b1, 25'h0000123);
      for (int k = 1; k <= 4; k++) begin
         tick();
         drive(1'b0, 1'b0, rnd());
         chk($sformatf("lat_cyc%0d", k), 32'(out_vld), 32'(k == 4));
      end
      chk("single_data", 32'(out_data), 32'h0000123);
      drain("single");

      // Backpressure: credit runs out after DEPTH grants; a negative value rides along.
      fill(grants, 2);
      chk("bp_grants", 32'(grants), 32'd8);
      chk("bp_level",  32'(level),  32'd8);
      chk("bp_in_rdy", 32'(in_rdy), 32'd0);
      chk("bp_ovf",    32'(ovf),    32'd0);
      drain("bp");

      // Full FIFO with push and pop every cycle: level pinned at DEPTH, nothing lost.
      fill(grants, -1);
      for (int j = 0; j < 16; j++) begin
         tick();
         chk($sformatf("full_level_%0d", j), 32'(level), 32'd8);
         out_rdy = (j >= 3);
         drive(j < 12, 1'b1, rnd());
      end
      chk("full_ovf", 32'(ovf), 32'd0);
      drain("full");

      // Overflow: sample forced against a full FIFO with no pop is dropped.
      fill(grants, -1);
      tick();
      drive(1'b1, 1'b0, rnd());
      for (int k = 1; k <= 4; k++) begin
         tick();
         drive(1'b0, 1'b0, rnd());
         chk($sformatf("ovf_cyc%0d", k), 32'(ovf), 32'(k == 4));
      end
      chk("ovf_level", 32'(level), 32'd8);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("ovf_cleared", 32'(ovf), 32'd0);
      tick();
      drive(1'b1, 1'b0, rnd());
      for (int k = 1; k <= 4; k++) begin
         tick();
         drive(1'b0, 1'b0, rnd());
         clr_ovf = (k == 3);
      end
      chk("ovf_set_wins", 32'(ovf), 32'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         out_rdy = 1'b1;
      end
      tick();
      out_rdy = 1'b0;
      chk("pre_rst_level", 32'(level), 32'd5);

      // Asynchronous reset mid-stream with entries queued and samples in flight.
      tick();
      drive(1'b1, 1'b1, rnd());
      tick();
      drive(1'b1, 1'b1, rnd());
      tick();
      drive(1'b0, 1'b0, rnd());
      #2 rst_b = 1'b0;
      exp_q.delete();
      #1;
      chk("arst_out_vld", 32'(out_vld), 32'd0);
      chk("arst_level",   32'(level),   32'd0);
      chk("arst_ovf",     32'(ovf),     32'd0);
      chk("arst_in_rdy",  32'(in_rdy),  32'd1);
      tick();
      tick();
      rst_b = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("post_rst_vld_%0d", k), 32'(out_vld), 32'd0);
      end

      // Random backpressure across several pointer wraps.
      issued = 0;
      for (int i = 0; i < 400 && issued < 32; i++) begin
         tick();
         out_rdy = 1'($urandom_range(0, 1));
         if (in_rdy) begin
            drive(1'b1, 1'b1, rnd());
            issued++;
         end else begin
            drive(1'b0, 1'b0, rnd());
         end
      end
      chk("rand_issued", 32'(issued), 32'd32);
      tick();
      drain("rand");
      chk("rand_ovf", 32'(ovf), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
